cpu_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the existing CPU datapath (program_counter, instruction_register, register_file, data_memory) through fetch/decode/execute/memory/writeback. It replaces the single-cycle direct enables with registered strobes and req/ready handshakes, so instruction and data memories may have variable latency. It also owns halt/error status and a retired-instruction counter.

---
 rtl/cpu_sequencer_if.sv | 44 ++++
 rtl/cpu_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
// Purpose: Bundles the control/handshake signals between cpu_sequencer and
//          the CPU datapath / instruction and data memories.
// Ports (as signals):
//   start, instruction, branch_taken      : datapath/host -> sequencer
//   imem_req / imem_ready                 : fetch handshake
//   dmem_req / dmem_we / dmem_ready       : data access handshake
//   ir_we, pc_we, pc_sel, reg_we, wb_sel  : datapath strobes and selects
//   state_out, halted, error, err_code    : status
//   instret                               : retired-instruction count
// Modports: master = sequencer side, slave = datapath/memory side.
interface cpu_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic [31:0]      instruction;
  logic             branch_taken;
  logic             imem_req;
  logic             imem_ready;
  logic             dmem_req;
  logic             dmem_we;
  logic             dmem_ready;
  logic             ir_we;
  logic             pc_we;
  logic [1:0]       pc_sel;
  logic             reg_we;
  logic [1:0]       wb_sel;
  logic [2:0]       state_out;
  logic             halted;
  logic             error;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] instret;

  modport master (
    input  start, instruction, branch_taken, imem_ready, dmem_ready,
    output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we,
           wb_sel, state_out, halted, error, err_code, instret
  );

  modport slave (
    output start, instruction, branch_taken, imem_ready, dmem_ready,
    input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we,
           wb_sel, state_out, halted, error, err_code, instret
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Purpose: Multi-cycle control FSM sequencing the CPU datapath through
//          fetch/decode/execute/memory/writeback with req/ready memory
//          handshakes, wait-limit timeout, sticky halt/error status and a
//          retired-instruction counter.
// Ports:
//   clock  : system clock
//   reset  : asynchronous, active-high reset
//   bus    : cpu_sequencer_if.master (handshakes, strobes, status)
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | waiting for start
// FETCH   | imem_req high until imem_ready; ir_we on ready
// DECODE  | classify instruction; halt/illegal exit here
// EXECUTE | ALU/branch/jump commit, or hand off to MEM
// MEM     | dmem_req (dmem_we for sw) until dmem_ready
// WB      | load writeback and PC commit
// HALT    | sticky halt, no strobes
// ERROR   | sticky error, err_code held
module cpu_sequencer #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 32
) (
  input logic             clock,
  input logic             reset,
  cpu_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  localparam int WW = $clog2(WAIT_LIMIT + 1);

  state_t           state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] instret_q;

  logic             imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we_raw;
  logic [1:0]       pc_sel, wb_sel;
  logic             limit_hit;

  // Decode
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_halt, is_alu, is_branch, is_jal, is_jalr, is_lw, is_sw, is_legal;

  assign opcode = bus.instruction[6:0];
  assign funct3 = bus.instruction[14:12];
  assign funct7 = bus.instruction[31:25];

  assign is_halt   = (bus.instruction == 32'hFFFF_FFFF);
  assign is_alu    = !is_halt &&
                     (((opcode == 7'b0110011) && (funct3 == 3'b000) &&
                       ((funct7 == 7'b0000000) || (funct7 == 7'b0100000))) ||
                      ((opcode == 7'b0010011) &&
                       ((funct3 == 3'b000) || (funct3 == 3'b001))));
  assign is_lw     = !is_halt && (opcode == 7'b0000011) && (funct3 == 3'b010);
  assign is_sw     = !is_halt && (opcode == 7'b0100011) && (funct3 == 3'b010);
  assign is_branch = !is_halt && (opcode == 7'b1100011) &&
                     ((funct3 == 3'b000) || (funct3 == 3'b001));
  assign is_jal    = !is_halt && (opcode == 7'b1101111);
  assign is_jalr   = !is_halt && (opcode == 7'b1100111) && (funct3 == 3'b000);
  assign is_legal  = is_alu || is_lw || is_sw || is_branch || is_jal || is_jalr;

  // Timeout fires on the WAIT_LIMIT-th unacknowledged cycle; a ready in that
  // same cycle is checked first so the access still completes.
  assign limit_hit = (wait_q == WW'(WAIT_LIMIT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      err_q     <= 2'd0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      if (pc_we) instret_q <= instret_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    err_d      = err_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 2'd0;
    reg_we_raw = 1'b0;
    wb_sel     = 2'd0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (limit_hit) begin
          state_d = S_ERROR;
          err_d   = 2'd2;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_DECODE: begin
        if (is_halt) begin
          state_d = S_HALT;
        end else if (!is_legal) begin
          state_d = S_ERROR;
          err_d   = 2'd1;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        wait_d = '0;
        if (is_alu) begin
          reg_we_raw = 1'b1;
          pc_we      = 1'b1;
          state_d    = S_FETCH;
        end else if (is_branch) begin
          pc_we   = 1'b1;
          pc_sel  = bus.branch_taken ? 2'd1 : 2'd0;
          state_d = S_FETCH;
        end else if (is_jal || is_jalr) begin
          reg_we_raw = 1'b1;
          wb_sel     = 2'd2;
          pc_we      = 1'b1;
          pc_sel     = is_jal ? 2'd2 : 2'd3;
          state_d    = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          // Unreachable via DECODE; trap rather than run on garbage.
          state_d = S_ERROR;
          err_d   = 2'd1;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        if (bus.dmem_ready) begin
          if (is_sw) begin
            pc_we   = 1'b1;
            wait_d  = '0;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (limit_hit) begin
          state_d = S_ERROR;
          err_d   = 2'd3;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_WB: begin
        reg_we_raw = 1'b1;
        wb_sel     = 2'd1;
        pc_we      = 1'b1;
        wait_d     = '0;
        state_d    = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.imem_req  = imem_req;
  assign bus.dmem_req  = dmem_req;
  assign bus.dmem_we   = dmem_we;
  assign bus.ir_we     = ir_we;
  assign bus.pc_we     = pc_we;
  assign bus.pc_sel    = pc_sel;
  // x0 is hardwired zero, so never strobe a write to it.
  assign bus.reg_we    = reg_we_raw && (bus.instruction[11:7] != 5'd0);
  assign bus.wb_sel    = wb_sel;
  assign bus.state_out = state_q;
  assign bus.halted    = (state_q == S_HALT);
  assign bus.error     = (state_q == S_ERROR);
  assign bus.err_code  = err_q;
  assign bus.instret   = instret_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
                         MEM = 3'd4, WB = 3'd5, HALT = 3'd6, ERROR = 3'd7;

  localparam logic [31:0] I_ADDI  = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] I_ADDI0 = 32'h0050_0013; // addi x0,x0,5
  localparam logic [31:0] I_ADD   = 32'h0020_81B3; // add x3,x1,x2
  localparam logic [31:0] I_SUB   = 32'h4020_81B3; // sub x3,x1,x2
  localparam logic [31:0] I_LW    = 32'h0000_2103; // lw x2,0(x0)
  localparam logic [31:0] I_SW    = 32'h0020_2023; // sw x2,0(x0)
  localparam logic [31:0] I_BEQ   = 32'h0000_0063;
  localparam logic [31:0] I_BNE   = 32'h0000_1063;
  localparam logic [31:0] I_JAL   = 32'h0000_00EF; // jal x1,0
  localparam logic [31:0] I_JALR  = 32'h0001_00E7; // jalr x1,0(x2)
  localparam logic [31:0] I_HALT  = 32'hFFFF_FFFF;
  localparam logic [31:0] I_ILL   = 32'h0000_007F;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  cpu_sequencer_if #(.CNT_W(32)) bus ();

  cpu_sequencer #(.WAIT_LIMIT(16), .CNT_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [12:0] v(input logic [2:0] st, input logic imr, dr, dw, irw, pcw,
                                    input logic [1:0] ps, input logic rw, input logic [1:0] ws);
    return {st, imr, dr, dw, irw, pcw, ps, rw, ws};
  endfunction

  function automatic logic [12:0] obs_vec();
    return {bus.state_out, bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_we,
            bus.pc_we, bus.pc_sel, bus.reg_we, bus.wb_sel};
  endfunction

  // Inputs are set at a negedge; outputs checked 1 ns later; then advance.
  task automatic cyc(input string tag, input logic [12:0] exp);
    #1;
    check(tag, 32'(obs_vec()), 32'(exp));
    @(negedge clock);
  endtask

  task automatic go();
    bus.start = 1'b1;
    cyc("idle", v(IDLE, 0,0,0,0,0, 2'd0, 0, 2'd0));
    bus.start = 1'b0;
  endtask

  task automatic fetch_decode(input logic [31:0] instr);
    bus.instruction = instr;
    bus.imem_ready  = 1'b1;
    cyc("fetch",  v(FETCH, 1,0,0,1,0, 2'd0, 0, 2'd0));
    cyc("decode", v(DECODE, 0,0,0,0,0, 2'd0, 0, 2'd0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    bus.start        = 1'b0;
    bus.instruction  = 32'h0;
    bus.branch_taken = 1'b0;
    bus.imem_ready   = 1'b0;
    bus.dmem_ready   = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Reset state
    check("rst_vec", 32'(obs_vec()), 32'(v(IDLE, 0,0,0,0,0, 2'd0, 0, 2'd0)));
    check("rst_status", {29'd0, bus.halted, bus.error, bus.err_code == 2'd0}, 32'd1);
    check("rst_instret", bus.instret, 32'd0);
    cyc("idle_nostart", v(IDLE, 0,0,0,0,0, 2'd0, 0, 2'd0));

    // addi x1 then halt
    go();
    fetch_decode(I_ADDI);
    cyc("exec_addi", v(EXEC, 0,0,0,0,1, 2'd0, 1, 2'd0));
    fetch_decode(I_HALT);
    #1;
    check("halted", {bus.state_out, bus.halted}, {HALT, 1'b1});
    check("instret_1", bus.instret, 32'd1);
    @(negedge clock);
    bus.start = 1'b1;
    cyc("halt_start_ign", v(HALT, 0,0,0,0,0, 2'd0, 0, 2'd0));
    cyc("halt_stay", v(HALT, 0,0,0,0,0, 2'd0, 0, 2'd0));
    bus.start = 1'b0;
    do_reset();

    // lw with three wait cycles, then sw likewise
    go();
    fetch_decode(I_LW);
    cyc("exec_lw", v(EXEC, 0,0,0,0,0, 2'd0, 0, 2'd0));
    bus.dmem_ready = 1'b0;
    repeat (3) cyc("lw_wait", v(MEM, 0,1,0,0,0, 2'd0, 0, 2'd0));
    bus.dmem_ready = 1'b1;
    cyc("lw_ready", v(MEM, 0,1,0,0,0, 2'd0, 0, 2'd0));
    bus.dmem_ready = 1'b0;
    cyc("wb_lw", v(WB, 0,0,0,0,1, 2'd0, 1, 2'd1));
    fetch_decode(I_SW);
    cyc("exec_sw", v(EXEC, 0,0,0,0,0, 2'd0, 0, 2'd0));
    repeat (3) cyc("sw_wait", v(MEM, 0,1,1,0,0, 2'd0, 0, 2'd0));
    bus.dmem_ready = 1'b1;
    cyc("sw_ready", v(MEM, 0,1,1,0,1, 2'd0, 0, 2'd0));
    bus.dmem_ready = 1'b0;
    check("instret_2", bus.instret, 32'd2);

    // Branches, jumps, rd=0 suppression, R-type
    bus.branch_taken = 1'b1;
    fetch_decode(I_BEQ);
    cyc("exec_beq_t", v(EXEC, 0,0,0,0,1, 2'd1, 0, 2'd0));
    bus.branch_taken = 1'b0;
    fetch_decode(I_BNE);
    cyc("exec_bne_nt", v(EXEC, 0,0,0,0,1, 2'd0, 0, 2'd0));
    fetch_decode(I_JAL);
    cyc("exec_jal", v(EXEC, 0,0,0,0,1, 2'd2, 1, 2'd2));
    fetch_decode(I_JALR);
    cyc("exec_jalr", v(EXEC, 0,0,0,0,1, 2'd3, 1, 2'd2));
    fetch_decode(I_ADDI0);
    cyc("exec_addi_x0", v(EXEC, 0,0,0,0,1, 2'd0, 0, 2'd0));
    fetch_decode(I_ADD);
    cyc("exec_add", v(EXEC, 0,0,0,0,1, 2'd0, 1, 2'd0));
    fetch_decode(I_SUB);
    cyc("exec_sub", v(EXEC, 0,0,0,0,1, 2'd0, 1, 2'd0));
    check("instret_9", bus.instret, 32'd9);

    // Fetch timeout
    bus.imem_ready = 1'b0;
    repeat (16) cyc("if_wait", v(FETCH, 1,0,0,0,0, 2'd0, 0, 2'd0));
    #1;
    check("if_to_vec", 32'(obs_vec()), 32'(v(ERROR, 0,0,0,0,0, 2'd0, 0, 2'd0)));
    check("if_to_code", {bus.error, bus.err_code}, {1'b1, 2'd2});
    @(negedge clock);
    bus.start = 1'b1;
    cyc("err_stay", v(ERROR, 0,0,0,0,0, 2'd0, 0, 2'd0));
    bus.start = 1'b0;
    check("err_code_held", bus.err_code, 32'd2);
    do_reset();
    check("err_cleared", {bus.error, bus.err_code}, 3'd0);

    // Data timeout
    go();
    fetch_decode(I_LW);
    cyc("exec_lw2", v(EXEC, 0,0,0,0,0, 2'd0, 0, 2'd0));
    repeat (16) cyc("dm_wait", v(MEM, 0,1,0,0,0, 2'd0, 0, 2'd0));
    #1;
    check("dm_to_vec", 32'(obs_vec()), 32'(v(ERROR, 0,0,0,0,0, 2'd0, 0, 2'd0)));
    check("dm_to_code", {bus.error, bus.err_code}, {1'b1, 2'd3});
    @(negedge clock);
    do_reset();

    // Ready on the 16th request cycle completes the fetch
    go();
    bus.imem_ready  = 1'b0;
    bus.instruction = I_ADDI;
    repeat (15) cyc("if_wait15", v(FETCH, 1,0,0,0,0, 2'd0, 0, 2'd0));
    bus.imem_ready = 1'b1;
    cyc("if_ready16", v(FETCH, 1,0,0,1,0, 2'd0, 0, 2'd0));
    cyc("decode_after16", v(DECODE, 0,0,0,0,0, 2'd0, 0, 2'd0));
    cyc("exec_after16", v(EXEC, 0,0,0,0,1, 2'd0, 1, 2'd0));
    check("no_err_16", {bus.error, bus.err_code}, 3'd0);

    // Illegal instruction
    fetch_decode(I_ILL);
    #1;
    check("ill_vec", 32'(obs_vec()), 32'(v(ERROR, 0,0,0,0,0, 2'd0, 0, 2'd0)));
    check("ill_code", {bus.error, bus.err_code}, {1'b1, 2'd1});
    check("ill_instret", bus.instret, 32'd1);
    @(negedge clock);
    do_reset();

    // Async reset during MEM wait
    go();
    fetch_decode(I_ADDI);
    cyc("exec_addi_b", v(EXEC, 0,0,0,0,1, 2'd0, 1, 2'd0));
    fetch_decode(I_SW);
    cyc("exec_sw_b", v(EXEC, 0,0,0,0,0, 2'd0, 0, 2'd0));
    repeat (2) cyc("sw_wait_b", v(MEM, 0,1,1,0,0, 2'd0, 0, 2'd0));
    check("instret_pre_rst", bus.instret, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_vec", 32'(obs_vec()), 32'(v(IDLE, 0,0,0,0,0, 2'd0, 0, 2'd0)));
    check("mid_rst_instret", bus.instret, 32'd0);
    check("mid_rst_status", {bus.halted, bus.error, bus.err_code}, 4'd0);
    @(negedge clock);
    reset = 1'b0;
    cyc("post_rst_idle", v(IDLE, 0,0,0,0,0, 2'd0, 0, 2'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
